// File: rtl/pio_event_scheduler_pkg.sv
// Shared types, constants and helpers for the PIO event scheduler.
package pio_event_scheduler_pkg;

    localparam int N_SRC_DEF = 2;
    localparam int DW_DEF    = 8;
    localparam int SW_DEF    = 1;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    // Add this cycle's drop count to the running total, clamped at DROP_MAX.
    function automatic logic [7:0] drop_sat_add(input logic [7:0] total, input logic [3:0] inc);
        logic [8:0] sum;
        sum = {1'b0, total} + {5'd0, inc};
        return (sum > {1'b0, DROP_MAX}) ? DROP_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/pio_event_scheduler_if.sv
// Event-source and CPU-PIO side signals of the scheduler.
interface pio_event_scheduler_if #(
    parameter int N_SRC = 2,
    parameter int DW    = 8,
    parameter int SW    = 1
);
    logic                EN_I;
    logic [N_SRC-1:0]    EVT_I;
    logic [N_SRC*DW-1:0] DATA_I;
    logic                ACK_I;
    logic                RDY_O;
    logic [SW-1:0]       SRC_O;
    logic [DW-1:0]       DAT_O;
    logic [N_SRC-1:0]    PEND_O;
    logic [7:0]          DROP_O;

    modport master (
        output EN_I, EVT_I, DATA_I, ACK_I,
        input  RDY_O, SRC_O, DAT_O, PEND_O, DROP_O
    );

    modport slave (
        input  EN_I, EVT_I, DATA_I, ACK_I,
        output RDY_O, SRC_O, DAT_O, PEND_O, DROP_O
    );
endinterface

// File: rtl/pio_event_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`, wrapping.
module pio_event_scheduler_rr_pick #(
    parameter int N_SRC = 2,
    parameter int SW    = 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SW-1:0]    last,
    output logic             any,
    output logic [SW-1:0]    idx
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            int  j;
            logic hit;
            j   = (int'(last) + k) % N_SRC;
            hit = req[j];
            any = any | hit;
            idx = hit ? SW'(j) : idx;
        end
    end

endmodule

// File: rtl/pio_event_scheduler.sv
// Shares one PIO input port between N_SRC event sources: 1-deep capture per source,
// round-robin grant, toggle-acknowledged handshake and a saturating drop counter.
module pio_event_scheduler
    import pio_event_scheduler_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int DW    = DW_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic                 CLK_I,
    input  logic                 RSTN_I,
    pio_event_scheduler_if.slave bus
);

    sched_state_e     state_r, state_nxt;
    logic             rdy_r, rdy_nxt;
    logic [SW-1:0]    src_r, src_nxt;
    logic [DW-1:0]    dat_r, dat_nxt;
    logic [SW-1:0]    ptr_r, ptr_nxt;
    logic [N_SRC-1:0] pend_r, pend_nxt;
    logic [DW-1:0]    cap_buf_r [N_SRC];
    logic [DW-1:0]    cap_buf_nxt [N_SRC];
    logic [7:0]       drop_r;
    logic [3:0]       drop_cnt_s;
    logic             ack_d_r;
    logic             ack_evt_s;
    logic             any_s;
    logic [SW-1:0]    pick_s;
    logic             grant_s;

    assign ack_evt_s = bus.ACK_I ^ ack_d_r;
    assign grant_s   = (state_r == ST_IDLE) && bus.EN_I && any_s;

    pio_event_scheduler_rr_pick #(.N_SRC(N_SRC), .SW(SW)) u_rr_pick (
        .req  (pend_r),
        .last (ptr_r),
        .any  (any_s),
        .idx  (pick_s)
    );

    // Capture and drop accounting; a strobe on the source being granted refills it.
    always_comb begin
        pend_nxt    = pend_r;
        cap_buf_nxt = cap_buf_r;
        drop_cnt_s  = 4'd0;
        for (int i = 0; i < N_SRC; i++) begin
            logic take;
            take = grant_s && (pick_s == SW'(i));
            if (bus.EVT_I[i]) begin
                if (pend_r[i] && !take) begin
                    drop_cnt_s = drop_cnt_s + 4'd1;
                end else begin
                    pend_nxt[i]    = 1'b1;
                    cap_buf_nxt[i] = bus.DATA_I[i*DW +: DW];
                end
            end else if (take) begin
                pend_nxt[i] = 1'b0;
            end else begin
                pend_nxt[i] = pend_r[i];
            end
        end
    end

    // Handshake FSM next-state and presented-word logic.
    always_comb begin
        state_nxt = state_r;
        rdy_nxt   = rdy_r;
        src_nxt   = src_r;
        dat_nxt   = dat_r;
        ptr_nxt   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt = ST_WAIT;
                    rdy_nxt   = 1'b1;
                    src_nxt   = pick_s;
                    dat_nxt   = cap_buf_r[pick_s];
                    ptr_nxt   = pick_s;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (ack_evt_s) begin
                    state_nxt = ST_GAP;
                    rdy_nxt   = 1'b0;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                rdy_nxt   = 1'b0;
            end
        endcase
    end

    // State, buffers, ack edge register and drop counter.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_r <= ST_IDLE;
            rdy_r   <= 1'b0;
            src_r   <= '0;
            dat_r   <= '0;
            ptr_r   <= SW'(N_SRC - 1);
            pend_r  <= '0;
            drop_r  <= 8'd0;
            ack_d_r <= bus.ACK_I;
            for (int i = 0; i < N_SRC; i++) begin
                cap_buf_r[i] <= '0;
            end
        end else begin
            state_r   <= state_nxt;
            rdy_r     <= rdy_nxt;
            src_r     <= src_nxt;
            dat_r     <= dat_nxt;
            ptr_r     <= ptr_nxt;
            pend_r    <= pend_nxt;
            drop_r    <= drop_sat_add(drop_r, drop_cnt_s);
            ack_d_r   <= bus.ACK_I;
            cap_buf_r <= cap_buf_nxt;
        end
    end

    assign bus.RDY_O  = rdy_r;
    assign bus.SRC_O  = src_r;
    assign bus.DAT_O  = dat_r;
    assign bus.PEND_O = pend_r;
    assign bus.DROP_O = drop_r;

endmodule
